// File: rtl/adc_line_buffer.sv
// Purpose: captures one line of ADC samples, then replays it continuously on read enable.
// Latency: one cycle from an accepted BUF_EN to ADC_OUT/OUT_VALID.
// Backpressure: none; BUF_EN with no line available is dropped and flagged as UNDERRUN.
module adc_line_buffer #(
    parameter int ADC_WIDHT = 14,
    parameter int DEPTH     = 640,
    parameter int ADDR_W    = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 MEM_MODE,
    input  logic                 START,
    input  logic [ADC_WIDHT-1:0] ADC_IN,
    input  logic                 ADC_VALID,
    input  logic                 BUF_EN,
    output logic [ADC_WIDHT-1:0] ADC_OUT,
    output logic                 OUT_VALID,
    output logic                 BUSY,
    output logic                 FULL,
    output logic                 UNDERRUN
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        READY    = 2'd2,
        PLAYBACK = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_ptr;
    logic                  start_ok;
    logic                  has_line;
    logic                  wr_en;
    logic                  wr_last;
    logic                  rd_en;
    logic                  underrun_set;
    logic [ADC_WIDHT-1:0]  mem [0:DEPTH-1];

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes; MEM_MODE=0 beats START, START beats capture-complete
    always_comb begin
        start_ok     = MEM_MODE & START;
        has_line     = (state == READY) || (state == PLAYBACK);
        wr_en        = MEM_MODE & ADC_VALID & (state == CAPTURE);
        // A restart inside CAPTURE writes this cycle's sample at address 0
        wr_ptr       = start_ok ? '0 : wr_addr;
        wr_last      = wr_en & ~start_ok & (wr_addr == LAST_ADDR);
        rd_en        = MEM_MODE & BUF_EN & has_line;
        underrun_set = MEM_MODE & BUF_EN & ~has_line;
        state_nxt    = state;
        if (!MEM_MODE) begin
            state_nxt = IDLE;
        end else if (start_ok) begin
            state_nxt = CAPTURE;
        end else begin
            case (state)
                IDLE:     state_nxt = IDLE;
                CAPTURE:  state_nxt = wr_last ? READY : CAPTURE;
                READY:    state_nxt = BUF_EN ? PLAYBACK : READY;
                PLAYBACK: state_nxt = PLAYBACK;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Write pointer: cleared on mode-off or restart, wraps to 0 after the last sample
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_addr <= '0;
        end else if (!MEM_MODE) begin
            wr_addr <= '0;
        end else if (start_ok) begin
            wr_addr <= wr_en ? ADDR_W'(1) : '0;
        end else if (wr_en) begin
            wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
        end
    end

    // Read pointer: advances only on accepted reads, wraps DEPTH-1 -> 0 so the line repeats
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_addr <= '0;
        end else if (!MEM_MODE || start_ok) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
        end
    end

    // Line RAM write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= ADC_IN;
        end
    end

    // Registered read port; output zeroed when memory mode is off, otherwise held between reads
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ADC_OUT   <= '0;
            OUT_VALID <= 1'b0;
        end else if (!MEM_MODE) begin
            ADC_OUT   <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= rd_en;
            if (rd_en) begin
                ADC_OUT <= mem[rd_addr];
            end
        end
    end

    // Sticky underrun flag, cleared only by an accepted START (held while MEM_MODE=0)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            UNDERRUN <= 1'b0;
        end else if (start_ok) begin
            UNDERRUN <= 1'b0;
        end else if (underrun_set) begin
            UNDERRUN <= 1'b1;
        end
    end

    assign BUSY = (state == CAPTURE);
    assign FULL = has_line;

endmodule

// File: tb/tb_adc_line_buffer.sv
module tb_adc_line_buffer;

    localparam int W     = 14;
    localparam int DEPTH = 640;
    localparam int AW    = 10;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         MEM_MODE = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] ADC_IN = '0;
    logic         ADC_VALID = 1'b0;
    logic         BUF_EN = 1'b0;
    logic [W-1:0] ADC_OUT;
    logic         OUT_VALID;
    logic         BUSY;
    logic         FULL;
    logic         UNDERRUN;

    adc_line_buffer #(.ADC_WIDHT(W), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .MEM_MODE(MEM_MODE), .START(START),
        .ADC_IN(ADC_IN), .ADC_VALID(ADC_VALID), .BUF_EN(BUF_EN),
        .ADC_OUT(ADC_OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY),
        .FULL(FULL), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: a captured line is just an array; capture is a growing queue
    logic [W-1:0] m_line [DEPTH];
    logic [W-1:0] cap_q [$];
    logic [W-1:0] exp_q [$];
    bit           m_cap, m_full, m_urun, m_vld;
    int           m_rd;
    logic [W-1:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cap = 0; m_full = 0; m_urun = 0; m_vld = 0; m_rd = 0; m_out = '0;
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic model_read();
        exp_q.push_back(m_line[m_rd]);
        m_out = m_line[m_rd];
        m_vld = 1;
        m_rd  = (m_rd + 1) % DEPTH;
    endtask

    task automatic model_step(input bit mm, input bit st, input bit vl,
                              input logic [W-1:0] din, input bit be);
        m_vld = 0;
        if (!mm) begin
            m_cap = 0; m_full = 0; m_rd = 0; m_out = '0;
            cap_q.delete();
        end else if (st) begin
            if (m_full && be) model_read();
            cap_q.delete();
            if (m_cap && vl) cap_q.push_back(din);
            m_cap = 1; m_full = 0; m_rd = 0; m_urun = 0;
        end else begin
            if (m_full) begin
                if (be) model_read();
            end else if (be) begin
                m_urun = 1;
            end
            if (m_cap && vl) begin
                cap_q.push_back(din);
                if (cap_q.size() == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) m_line[i] = cap_q[i];
                    cap_q.delete();
                    m_cap  = 0;
                    m_full = 1;
                end
            end
        end
    endtask

    // One clock of stimulus; status outputs compared #1 after the edge
    task automatic step(input bit mm, input bit st, input bit vl,
                        input logic [W-1:0] din, input bit be);
        MEM_MODE = mm; START = st; ADC_VALID = vl; ADC_IN = din; BUF_EN = be;
        model_step(mm, st, vl, din, be);
        @(posedge CLK);
        #1;
        chk("busy",      {31'd0, BUSY},      {31'd0, m_cap});
        chk("full",      {31'd0, FULL},      {31'd0, m_full});
        chk("underrun",  {31'd0, UNDERRUN},  {31'd0, m_urun});
        chk("out_valid", {31'd0, OUT_VALID}, {31'd0, m_vld});
        chk("adc_out",   {18'd0, ADC_OUT},   {18'd0, m_out});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_adc_out"},   {18'd0, ADC_OUT},   32'd0);
        chk({tag, "_out_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_busy"},      {31'd0, BUSY},      32'd0);
        chk({tag, "_full"},      {31'd0, FULL},      32'd0);
        chk({tag, "_underrun"},  {31'd0, UNDERRUN},  32'd0);
    endtask

    // Scoreboard monitor: every presented sample must match the oldest expected one
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got valid sample %0h expected none", ADC_OUT);
            end else begin
                chk("sb_data", {18'd0, ADC_OUT}, {18'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int busy_cnt;
        int guard;
        logic [W-1:0] r;

        model_reset();
        #12;
        check_reset_outputs("reset");
        #2 RST_N = 1'b1;

        // Idle in memory mode, read attempts before any capture
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 0);

        // Arm capture (clears underrun), then ramp 0..639
        step(1, 1, 0, '0, 0);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (BUSY) busy_cnt++;
            step(1, 0, 1, W'(i), 0);
        end
        chk("busy_cycles", busy_cnt, DEPTH);
        chk("full_after_capture", {31'd0, FULL}, 32'd1);

        // Continuous playback across two wraps
        for (int i = 0; i < 1300; i++) step(1, 0, 0, '0, 1);
        // Gapped playback
        for (int i = 0; i < 300; i++) step(1, 0, 0, '0, 1'($urandom_range(0, 1)));

        // Restart from playback with a read in the same cycle
        step(1, 1, 0, '0, 1);
        // Partial capture of 300 random samples with gaps, some underrun attempts
        guard = 0;
        while (cap_q.size() < 300 && guard < 2000) begin
            r = W'($urandom_range(0, 16383));
            step(1, 0, 1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 15) == 0));
            guard++;
        end
        // Restart inside capture; this cycle's sample lands at address 0
        step(1, 1, 1, 14'h3FFF, 0);
        guard = 0;
        while (!m_full && guard < 4000) begin
            step(1, 0, 1'($urandom_range(0, 3) != 0), 14'h3FFF, 0);
            guard++;
        end
        chk("restart_full", {31'd0, FULL}, 32'd1);
        for (int i = 0; i < 700; i++) step(1, 0, 0, '0, 1'($urandom_range(0, 3) != 0));
        step(1, 0, 0, '0, 1);

        // Drop memory mode mid-playback
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, '0, 1);
        step(1, 0, 0, '0, 0);

        // Third capture with random data, then full playback
        step(1, 1, 0, '0, 0);
        guard = 0;
        while (!m_full && guard < 4000) begin
            r = W'($urandom_range(0, 16383));
            step(1, 0, 1'($urandom_range(0, 1)), r, 0);
            guard++;
        end
        for (int i = 0; i < 700; i++) step(1, 0, 0, '0, 1'($urandom_range(0, 1)));

        // Asynchronous reset pulse mid-capture
        step(1, 1, 0, '0, 0);
        for (int i = 0; i < 200; i++) step(1, 0, 1, W'($urandom_range(0, 16383)), 0);
        #1 RST_N = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        #1 RST_N = 1'b1;
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 0);

        repeat (3) @(posedge CLK);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_line_buffer.md
Name: adc_line_buffer

Overview:
Single-clock line buffer between the ADC capture path and the VGA path. In memory mode it captures one line of DEPTH ADC samples from the memory-side ADC stream. It then plays the line back continuously, one sample per VGA read-enable, as the buffered data returned to the memory/VGA switch. It runs on the switched buffer clock and sits directly downstream of the switch's memory-side outputs and upstream of its buffer-return input.

Parameters:
ADC_WIDHT, 14, sample width in bits
DEPTH, 640, samples per line (2..2^ADDR_W)
ADDR_W, 10, RAM address width

Ports:
CLK  input  1  buffer clock (switched 25/100 MHz); all logic on rising edge
RST_N  input  1  asynchronous active-low reset
MEM_MODE  input  1  1 = memory mode enabled; 0 forces IDLE
START  input  1  single-cycle pulse: arm a new capture
ADC_IN  input  ADC_WIDHT  memory-side ADC sample
ADC_VALID  input  1  ADC_IN valid this cycle
BUF_EN  input  1  read enable (buffer input enable from switch)
ADC_OUT  output  ADC_WIDHT  buffered sample to switch
OUT_VALID  output  1  ADC_OUT holds a sample read this line
BUSY  output  1  capture in progress
FULL  output  1  line captured, playback allowed
UNDERRUN  output  1  sticky: BUF_EN seen with no line available

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE, wr_addr=0, rd_addr=0, ADC_OUT=0, OUT_VALID=0, BUSY=0, FULL=0, UNDERRUN=0. RAM contents are not reset.
- Internal RAM: DEPTH x ADC_WIDHT, one write port and one read port, synchronous read.
- States: IDLE, CAPTURE, READY, PLAYBACK.
- IDLE: START & MEM_MODE -> CAPTURE, wr_addr=0, BUSY=1, FULL=0, UNDERRUN=0.
- CAPTURE: each cycle with ADC_VALID=1, write ADC_IN to RAM[wr_addr] and increment wr_addr. The write at wr_addr=DEPTH-1 -> READY next cycle, BUSY=0, FULL=1, wr_addr=0. ADC_VALID=0 leaves wr_addr unchanged.
- READY: BUF_EN=1 -> PLAYBACK. The read of RAM[rd_addr] is issued the same cycle.
- PLAYBACK: each BUF_EN=1 cycle issues a read at rd_addr. rd_addr increments and wraps from DEPTH-1 to 0, so the line repeats indefinitely. BUF_EN=0 holds rd_addr.
- Read latency: exactly 1 cycle. ADC_OUT and OUT_VALID are registered. OUT_VALID(t+1) = BUF_EN(t) & (state was READY or PLAYBACK at t). When OUT_VALID=0, ADC_OUT holds its last value.
- Underrun: BUF_EN=1 in IDLE or CAPTURE sets UNDERRUN (sticky). No read is issued and OUT_VALID=0. UNDERRUN clears only on an accepted START or on reset.
- START in CAPTURE: restart capture. wr_addr=0, samples already written are discarded, and the ADC_VALID write that cycle goes to address 0.
- START in READY or PLAYBACK: -> CAPTURE, rd_addr=0, FULL=0. A read issued the same cycle still produces its OUT_VALID on the next cycle.
- MEM_MODE=0 in any state: synchronous return to IDLE next cycle. BUSY=0, FULL=0, rd_addr=0, wr_addr=0, OUT_VALID=0. ADC_OUT is forced to 0, matching the switch's zero output when memory mode is off. UNDERRUN is held.
- MEM_MODE=0 has priority over START. START has priority over the capture-complete transition.
- Asserting RST_N mid-capture or mid-playback aborts immediately to the reset values; the RAM keeps stale data but FULL=0 makes it unreadable.
- Widths: addresses are ADDR_W bits. Wrap compares against DEPTH-1 explicitly, so non-power-of-two DEPTH is supported. No arithmetic is performed on sample data.

Test Plan:
- Reset then MEM_MODE=1, START, 640 samples ADC_IN=0..639 with ADC_VALID=1 -> BUSY high for 640 cycles; FULL=1 on the cycle after the last write; BUSY=0.
- After capture, BUF_EN=1 for 1300 cycles -> ADC_OUT = 0,1,..,639,0,1,.. starting one cycle after the first BUF_EN; OUT_VALID continuous; wrap seamless at 639->0.
- BUF_EN toggling 1/0 during playback -> rd_addr advances only on enabled cycles; output sequence 0,1,2,.. with no skips or repeats.
- BUF_EN=1 before any capture -> UNDERRUN=1, OUT_VALID=0, ADC_OUT=0; a following START clears UNDERRUN.
- START after 300 captured samples, then 640 samples of value 0x3FFF -> FULL after the new 640; playback returns all 0x3FFF (no 0..299 remnants).
- MEM_MODE dropped mid-playback -> next cycle state IDLE, ADC_OUT=0, OUT_VALID=0, FULL=0. RST_N pulse mid-capture -> all outputs at reset values asynchronously.
